// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the front-end pipeline sequencer.
package pipeline_ctrl_pkg;

    // Sequencer modes.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH      = 2'd1,
        FETCH_WAIT = 2'd2,
        FAULT      = 2'd3
    } state_t;

    // Highest-priority hazard cause seen in RUN / FETCH_WAIT.
    typedef enum logic [2:0] {
        NONE      = 3'd0,
        REDIRECT  = 3'd1,
        EX_BUSY   = 3'd2,
        LOAD_USE  = 3'd3,
        IMEM_WAIT = 3'd4
    } cause_t;

    // Register x0 is hardwired to zero and never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bundle of per-stage pipeline register controls.
    typedef struct packed {
        logic pc_en;
        logic pc_sel_redirect;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
    } ctrl_t;

    // Priority encoder for the hazard causes, highest priority first.
    function automatic cause_t pick_cause(
        input logic redirect,
        input logic busy,
        input logic load_use,
        input logic imem_valid
    );
        if (redirect)
            return REDIRECT;
        else if (busy)
            return EX_BUSY;
        else if (load_use)
            return LOAD_USE;
        else if (!imem_valid)
            return IMEM_WAIT;
        else
            return NONE;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the ID and EX stages.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // A load in EX blocks the ID instruction only if ID really reads its non-zero target.
    always_comb begin
        rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
        load_use = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Front-end pipeline sequencer: turns redirect, EX-busy, load-use and
// instruction-memory wait hazards into PC / IF-ID / ID-EX enables and flushes.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int IMEM_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             ex_busy,
    input  logic             imem_valid,
    output logic             pc_en,
    output logic             pc_sel_redirect,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(IMEM_TIMEOUT + 1);
    localparam int FL_W   = 2;

    localparam logic [WAIT_W-1:0] TIMEOUT_VAL  = WAIT_W'(IMEM_TIMEOUT);
    localparam logic [FL_W-1:0]   FLUSH_RELOAD = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic [FL_W-1:0]   flrem_q, flrem_d;
    logic [CNT_W-1:0]  stall_q, flush_q;

    logic   load_use;
    logic   redirect;
    logic   take_redirect;
    cause_t cause;
    ctrl_t  ctl;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    // Cause decode; a busy EX stage cannot redirect because its result is not final.
    always_comb begin
        redirect      = ex_redirect && !ex_busy;
        take_redirect = redirect && (state_q != FAULT);
        cause         = pick_cause(redirect, ex_busy, load_use, imem_valid);
        wait_inc      = wait_q + 1'b1;
    end

    // Next-state and zero-latency stage controls.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        wait_d  = wait_q;
        flrem_d = flrem_q;
        ctl     = '0;

        if (rst) begin
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
            state_d         = RUN;
        end else if (take_redirect) begin
            ctl     = '1;
            wait_d  = '0;
            flrem_d = FLUSH_RELOAD;
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else begin
            case (state_q)
                RUN, FETCH_WAIT: begin
                    case (cause)
                        EX_BUSY: begin
                            // Hold every stage; state and wait count stay put.
                        end
                        LOAD_USE: begin
                            ctl.id_ex_en    = 1'b1;
                            ctl.id_ex_flush = 1'b1;
                        end
                        IMEM_WAIT: begin
                            ctl.if_id_en    = 1'b1;
                            ctl.if_id_flush = 1'b1;
                            ctl.id_ex_en    = 1'b1;
                            wait_d          = wait_inc;
                            state_d         = (wait_inc == TIMEOUT_VAL) ? FAULT : FETCH_WAIT;
                        end
                        default: begin
                            ctl.pc_en    = 1'b1;
                            ctl.if_id_en = 1'b1;
                            ctl.id_ex_en = 1'b1;
                            wait_d       = '0;
                            state_d      = RUN;
                        end
                    endcase
                end
                FLUSH: begin
                    ctl.if_id_en    = 1'b1;
                    ctl.if_id_flush = 1'b1;
                    ctl.pc_en       = imem_valid && !ex_busy;
                    ctl.id_ex_en    = !ex_busy;
                    if (flrem_q <= FL_W'(1)) begin
                        flrem_d = '0;
                        state_d = RUN;
                    end else begin
                        flrem_d = flrem_q - 1'b1;
                    end
                end
                FAULT: begin
                    ctl.if_id_flush = 1'b1;
                    ctl.id_ex_flush = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            flrem_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            flrem_q <= flrem_d;
        end
    end

    // Saturating statistics: PC-stall cycles and accepted redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!ctl.pc_en && (stall_q != CNT_MAX))
                stall_q <= stall_q + 1'b1;
            if (take_redirect && (flush_q != CNT_MAX))
                flush_q <= flush_q + 1'b1;
        end
    end

    // Output wiring.
    always_comb begin
        pc_en           = ctl.pc_en;
        pc_sel_redirect = ctl.pc_sel_redirect;
        if_id_en        = ctl.if_id_en;
        if_id_flush     = ctl.if_id_flush;
        id_ex_en        = ctl.id_ex_en;
        id_ex_flush     = ctl.id_ex_flush;
        fetch_fault     = (state_q == FAULT) && !rst;
        stall_cnt       = stall_q;
        flush_cnt       = flush_q;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver pushes reference-model
// expectations, the monitor pops and compares on the falling edge.
module tb_pipeline_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int IMEM_TIMEOUT = 4;
    localparam int CNT_W        = 8;
    localparam int SAT          = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       mem_read;
        logic [4:0] rd;
        logic       redirect;
        logic       busy;
        logic       imem_valid;
    } stim_t;

    typedef struct packed {
        logic             pc_en;
        logic             pc_sel;
        logic             if_en;
        logic             if_fl;
        logic             ex_en;
        logic             ex_fl;
        logic             fault;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, ex_busy, imem_valid;
    logic             pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, fetch_fault;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    entry_t exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    // Reference model: counts of remaining flush cycles and consecutive misses.
    int m_flush_left = 0;
    int m_misses     = 0;
    int m_stall      = 0;
    int m_flush      = 0;
    bit m_faulted    = 0;

    pipeline_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .IMEM_TIMEOUT (IMEM_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_redirect     (ex_redirect),
        .ex_busy         (ex_busy),
        .imem_valid      (imem_valid),
        .pc_en           (pc_en),
        .pc_sel_redirect (pc_sel_redirect),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_flush     (id_ex_flush),
        .fetch_fault     (fetch_fault),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got pc/sel/ifen/iffl/exen/exfl/fault=%b%b%b%b%b%b%b stall=%0d flush=%0d, required %b%b%b%b%b%b%b stall=%0d flush=%0d",
                     name, $time, got.pc_en, got.pc_sel, got.if_en, got.if_fl, got.ex_en, got.ex_fl,
                     got.fault, got.stall, got.flush, exp.pc_en, exp.pc_sel, exp.if_en, exp.if_fl,
                     exp.ex_en, exp.ex_fl, exp.fault, exp.stall, exp.flush);
        end
    endtask

    // Expected outputs for this cycle, then advance the model by one clock.
    task automatic model_step(input stim_t s, output obs_t e);
        bit lu;
        bit redir;
        e       = '0;
        e.stall = CNT_W'(m_stall);
        e.flush = CNT_W'(m_flush);
        lu = s.mem_read && (s.rd != 5'd0) &&
             ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
        redir = s.redirect && !s.busy;
        if (s.rst) begin
            e.if_fl = 1'b1;
            e.ex_fl = 1'b1;
            m_flush_left = 0;
            m_misses     = 0;
            m_faulted    = 0;
            m_stall      = 0;
            m_flush      = 0;
        end else begin
            if (m_faulted) begin
                e.if_fl = 1'b1;
                e.ex_fl = 1'b1;
                e.fault = 1'b1;
            end else if (redir) begin
                {e.pc_en, e.pc_sel, e.if_en, e.if_fl, e.ex_en, e.ex_fl} = 6'b111111;
                m_flush      = (m_flush < SAT) ? m_flush + 1 : SAT;
                m_misses     = 0;
                m_flush_left = FLUSH_CYCLES - 1;
            end else if (m_flush_left > 0) begin
                e.if_en = 1'b1;
                e.if_fl = 1'b1;
                e.pc_en = s.imem_valid && !s.busy;
                e.ex_en = !s.busy;
                m_flush_left--;
            end else if (s.busy) begin
                // full hold
            end else if (lu) begin
                e.ex_en = 1'b1;
                e.ex_fl = 1'b1;
            end else if (!s.imem_valid) begin
                e.if_en = 1'b1;
                e.if_fl = 1'b1;
                e.ex_en = 1'b1;
                m_misses++;
                if (m_misses == IMEM_TIMEOUT) m_faulted = 1;
            end else begin
                e.pc_en = 1'b1;
                e.if_en = 1'b1;
                e.ex_en = 1'b1;
                m_misses = 0;
            end
            if (!e.pc_en) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        end
    endtask

    // One clock of stimulus; the expectation goes to the scoreboard.
    task automatic drive(input stim_t s, input string name);
        entry_t ent;
        @(posedge clk);
        #1;
        rst         = s.rst;
        id_rs1      = s.rs1;
        id_rs2      = s.rs2;
        id_use_rs1  = s.use1;
        id_use_rs2  = s.use2;
        ex_mem_read = s.mem_read;
        ex_rd       = s.rd;
        ex_redirect = s.redirect;
        ex_busy     = s.busy;
        imem_valid  = s.imem_valid;
        ent.name = name;
        model_step(s, ent.exp);
        exp_q.push_back(ent);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.imem_valid = 1'b1;
        return s;
    endfunction

    // Monitor: outputs are valid every cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            entry_t ent;
            ent = exp_q.pop_front();
            check(ent.name, {pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en,
                             id_ex_flush, fetch_fault, stall_cnt, flush_cnt}, ent.exp);
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, ex_busy} = '0;
        imem_valid = 1'b1;

        s = idle(); s.rst = 1'b1;
        repeat (2) drive(s, "reset");
        repeat (2) drive(idle(), "run");

        // Load x5 followed by a dependent rs1 read.
        s = idle(); s.mem_read = 1; s.rd = 5'd5; s.use1 = 1; s.rs1 = 5'd5;
        drive(s, "load_use_rs1");
        drive(idle(), "load_use_after");

        // No hazard through x0, nor through an unused rs2.
        s = idle(); s.mem_read = 1; s.rd = 5'd0; s.use1 = 1; s.rs1 = 5'd0;
        drive(s, "load_x0");
        s = idle(); s.mem_read = 1; s.rd = 5'd5; s.use2 = 0; s.rs2 = 5'd5;
        drive(s, "unused_rs2");

        // Single redirect then the extra flush cycle.
        s = idle(); s.redirect = 1;
        drive(s, "redirect");
        repeat (3) drive(idle(), "redirect_tail");

        // EX busy masks both redirect and load-use.
        s = idle(); s.busy = 1; s.redirect = 1; s.mem_read = 1; s.rd = 5'd7; s.use1 = 1; s.rs1 = 5'd7;
        repeat (3) drive(s, "busy_hold");
        repeat (2) drive(idle(), "busy_after");

        // Fetch waits: one short of timeout, then exactly the timeout.
        s = idle(); s.imem_valid = 0;
        repeat (3) drive(s, "imem_wait3");
        drive(idle(), "imem_recover");
        repeat (4) drive(s, "imem_wait4");
        repeat (3) drive(idle(), "fault_sticky");
        s = idle(); s.rst = 1;
        drive(s, "fault_reset");
        repeat (2) drive(idle(), "post_fault");

        // Reset in the middle of a flush.
        s = idle(); s.redirect = 1;
        drive(s, "redirect2");
        s = idle(); s.rst = 1;
        drive(s, "reset_in_flush");
        repeat (3) drive(idle(), "post_flush_reset");

        // Stall counter saturation while faulted.
        s = idle(); s.imem_valid = 0;
        repeat (4) drive(s, "to_fault");
        repeat (270) drive(idle(), "stall_sat");
        s = idle(); s.rst = 1;
        drive(s, "sat_reset");

        // Flush counter saturation with back-to-back redirects.
        s = idle(); s.redirect = 1;
        repeat (300) drive(s, "flush_sat");
        s = idle(); s.rst = 1;
        drive(s, "sat_reset2");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s            = '0;
            s.rst        = ($urandom_range(0, 99) < 3);
            s.rs1        = 5'($urandom_range(0, 3));
            s.rs2        = 5'($urandom_range(0, 3));
            s.rd         = 5'($urandom_range(0, 3));
            s.use1       = 1'($urandom_range(0, 1));
            s.use2       = 1'($urandom_range(0, 1));
            s.mem_read   = ($urandom_range(0, 99) < 30);
            s.redirect   = ($urandom_range(0, 99) < 10);
            s.busy       = ($urandom_range(0, 99) < 15);
            s.imem_valid = ($urandom_range(0, 99) < 80);
            drive(s, "random");
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
